div_period_mon: RTL and testbench
=================================

// Module: div_period_mon
// PURPOSE
//   Downstream checker for the fractional clock divider's output (e.g. the 8.7 divider).
//   - Samples the divided signal in the clk_in domain and measures each rise-to-rise period.
//   - Sums every block of WIN_N periods and checks each period and each sum against limits.
//   - Reports lock status, per-event error pulses and a sticky error for status/BIST logic.
// PARAMETERS
//   PER_MIN  8    minimum legal period, clk_in cycles
//   PER_MAX  9    maximum legal period, clk_in cycles; also the timeout limit
//   WIN_N    10   number of periods per window
//   WIN_SUM  87   required window total (8.7 x 10)
//   CNT_W    $clog2(PER_MAX+1)         period counter / per_len width
//   SUM_W    $clog2(WIN_N*PER_MAX+1)   window accumulator / win_sum width
// PORTS
//   clk_in      in   1      single clock; all logic on its rising edge
//   rst         in   1      asynchronous, active-low reset
//   clk_div_in  in   1      divider output, synchronous to clk_in
//   clr         in   1      synchronous clear of err_sticky
//   per_len     out  CNT_W  last measured period
//   per_vld     out  1      1-cycle pulse: per_len updated
//   win_sum     out  SUM_W  last window total
//   win_vld     out  1      1-cycle pulse: win_sum updated
//   err_per     out  1      1-cycle pulse: period out of range or timeout
//   err_win     out  1      1-cycle pulse: win_sum != WIN_SUM
//   err_sticky  out  1      set by any error pulse; cleared by clr
//   locked      out  1      high after a clean window; low on any error
// BEHAVIOUR
//   - Reset (rst=0): every register and output goes to 0 immediately, including the FSM,
//     which enters IDLE. Reset mid-window discards all partial state.
//   - Edge detect: d1 <= clk_div_in. rise = clk_div_in & ~d1, combinational.
//   - FSM IDLE: waits for rise. On rise: pcnt <= 1, wcnt <= 0, acc <= 0, go to MEAS.
//     The first rise never produces per_vld.
//   - FSM MEAS, on rise:
//     - pcnt <= 1.
//     - per_len <= pcnt and per_vld <= 1, both registered.
//       Latency: outputs are valid one cycle after clk_div_in is first sampled high.
//     - err_per <= (pcnt < PER_MIN) || (pcnt > PER_MAX).
//     - If wcnt == WIN_N-1:
//       - win_sum <= acc + pcnt, with win_vld in the same cycle as per_vld.
//       - err_win <= (acc + pcnt != WIN_SUM).
//       - acc <= 0, wcnt <= 0.
//     - Otherwise: acc <= acc + pcnt, wcnt <= wcnt + 1.
//   - FSM MEAS, no rise:
//     - If pcnt == PER_MAX (timeout): err_per pulses next cycle, per_vld stays 0,
//       locked <= 0, state goes to IDLE.
//     - Otherwise: pcnt <= pcnt + 1. The counter can never wrap.
//   - Blocks are non-overlapping windows of WIN_N periods, starting at the first measured
//     period. No phase alignment is needed: any WIN_N consecutive periods of a good stream
//     sum to WIN_SUM.
//   - locked:
//     - Set on win_vld when err_win = 0 and no err_per occurred within that window.
//     - Cleared in the same cycle as any err_per or err_win pulse.
//   - err_sticky:
//     - Set by any err_per or err_win pulse; cleared by clr.
//     - Error and clr in the same cycle: set wins.
//   - Arithmetic: all unsigned. acc and win_sum are SUM_W bits; pcnt is zero-extended.
// TESTING
//   - Repeat 9,9,8,9,9,8,9,9,9,8 for 3 windows
//     -> per_len follows the pattern, win_sum = 87 x3, locked = 1 after first win_vld, no errors.
//   - Inject one 7-cycle period
//     -> err_per with per_len = 7, locked = 0, that window gives win_sum = 86 with err_win,
//        err_sticky = 1.
//   - Constant 9-cycle periods -> err_per = 0, win_sum = 90 with err_win, locked stays 0.
//   - Hold clk_div_in low after a rise
//     -> err_per 10 cycles after that rise, FSM in IDLE, locked = 0;
//        next rise gives no per_vld; the rise after it gives per_vld.
//   - Pulse clr alone -> err_sticky = 0. Pulse clr in the same cycle as err_win -> err_sticky = 1.
//   - Assert rst mid-window
//     -> all outputs 0 asynchronously; after release, first measured window sums 87 cleanly.

Source files
------------

// File: rtl/div_period_mon_if.sv
// div_period_mon_if: connection bundle between a divided-clock source and its
// period monitor.
//   master modport : the side that produces clk_div_in / clr and observes results
//   slave  modport : the monitor itself (div_period_mon)
// Signals:
//   clk_div_in  divider output, synchronous to the monitor clock
//   clr         synchronous clear of err_sticky
//   per_len     last measured period (clk_in cycles)
//   per_vld     1-cycle pulse: per_len updated
//   win_sum     last window total
//   win_vld     1-cycle pulse: win_sum updated
//   err_per     1-cycle pulse: period out of range or timeout
//   err_win     1-cycle pulse: window total wrong
//   err_sticky  latched error, cleared by clr
//   locked      high after a clean window, low on any error
//   dbg_state   monitor FSM state (0 = IDLE, 1 = MEAS)
// Valid semantics: there is no back-pressure. per_vld and win_vld are single
// cycle strobes; the data they qualify (per_len, win_sum) holds its value
// until the next strobe, and err_per / err_win are only meaningful alongside
// them (except err_per on a timeout, which comes without per_vld).
interface div_period_mon_if #(
  parameter int PER_MAX = 9,
  parameter int WIN_N   = 10,
  parameter int CNT_W   = $clog2(PER_MAX + 1),
  parameter int SUM_W   = $clog2(WIN_N * PER_MAX + 1)
);
  logic             clk_div_in;
  logic             clr;
  logic [CNT_W-1:0] per_len;
  logic             per_vld;
  logic [SUM_W-1:0] win_sum;
  logic             win_vld;
  logic             err_per;
  logic             err_win;
  logic             err_sticky;
  logic             locked;
  logic             dbg_state;

  modport master (
    output clk_div_in, clr,
    input  per_len, per_vld, win_sum, win_vld, err_per, err_win,
           err_sticky, locked, dbg_state
  );

  modport slave (
    input  clk_div_in, clr,
    output per_len, per_vld, win_sum, win_vld, err_per, err_win,
           err_sticky, locked, dbg_state
  );
endinterface

// File: rtl/div_period_mon.sv
// div_period_mon: checks the output of a fractional clock divider.
// Measures every rise-to-rise period of clk_div_in in clk_in cycles, sums
// non-overlapping blocks of WIN_N periods, flags out-of-range periods,
// timeouts and wrong window totals, and keeps lock / sticky-error status.
// Ports:
//   clk_in  single clock, rising edge
//   rst     asynchronous active-low reset
//   mon     div_period_mon_if.slave (clk_div_in, clr in; results out)
module div_period_mon #(
  parameter int PER_MIN = 8,
  parameter int PER_MAX = 9,
  parameter int WIN_N   = 10,
  parameter int WIN_SUM = 87
) (
  input  logic            clk_in,
  input  logic            rst,
  div_period_mon_if.slave mon
);
  localparam int CNT_W  = $clog2(PER_MAX + 1);
  localparam int SUM_W  = $clog2(WIN_N * PER_MAX + 1);
  localparam int WCNT_W = (WIN_N > 1) ? $clog2(WIN_N) : 1;

  typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              d1_q, d1_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic              win_bad_q, win_bad_d;   // an err_per happened in this window
  logic [CNT_W-1:0]  per_len_q, per_len_d;
  logic              per_vld_q, per_vld_d;
  logic [SUM_W-1:0]  win_sum_q, win_sum_d;
  logic              win_vld_q, win_vld_d;
  logic              err_per_q, err_per_d;
  logic              err_win_q, err_win_d;
  logic              locked_q, locked_d;
  logic              sticky_q, sticky_d;

  logic             rise;
  logic             per_bad;
  logic             last_per;
  logic             timeout;
  logic [SUM_W-1:0] per_sum;

  assign rise     = mon.clk_div_in & ~d1_q;
  assign per_bad  = (pcnt_q < CNT_W'(PER_MIN)) || (pcnt_q > CNT_W'(PER_MAX));
  assign last_per = (wcnt_q == WCNT_W'(WIN_N - 1));
  assign timeout  = (pcnt_q == CNT_W'(PER_MAX));
  assign per_sum  = acc_q + SUM_W'(pcnt_q);

  // State register
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = MEAS;
      MEAS:    if (!rise && timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    d1_d      = mon.clk_div_in;
    pcnt_d    = pcnt_q;
    wcnt_d    = wcnt_q;
    acc_d     = acc_q;
    win_bad_d = win_bad_q;
    per_len_d = per_len_q;
    per_vld_d = 1'b0;
    win_sum_d = win_sum_q;
    win_vld_d = 1'b0;
    err_per_d = 1'b0;
    err_win_d = 1'b0;
    locked_d  = locked_q;
    case (state_q)
      IDLE: begin
        // First rise only opens the measurement; nothing to report yet.
        if (rise) begin
          pcnt_d    = CNT_W'(1);
          wcnt_d    = '0;
          acc_d     = '0;
          win_bad_d = 1'b0;
        end
      end
      MEAS: begin
        if (rise) begin
          pcnt_d    = CNT_W'(1);
          per_len_d = pcnt_q;
          per_vld_d = 1'b1;
          err_per_d = per_bad;
          if (last_per) begin
            win_sum_d = per_sum;
            win_vld_d = 1'b1;
            err_win_d = (per_sum != SUM_W'(WIN_SUM));
            acc_d     = '0;
            wcnt_d    = '0;
            win_bad_d = 1'b0;
            if ((per_sum == SUM_W'(WIN_SUM)) && !win_bad_q && !per_bad)
              locked_d = 1'b1;
          end else begin
            acc_d     = per_sum;
            wcnt_d    = wcnt_q + 1'b1;
            win_bad_d = win_bad_q | per_bad;
          end
        end else if (timeout) begin
          // Signal lost: report and wait for a fresh rise in IDLE.
          err_per_d = 1'b1;
        end else begin
          // Stops at PER_MAX via the timeout branch, so it never wraps.
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (err_per_d || err_win_d) locked_d = 1'b0;
    // Driven from the visible error pulses so a clr coinciding with a pulse
    // loses to it.
    sticky_d = err_per_q | err_win_q | (sticky_q & ~mon.clr);
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      d1_q      <= 1'b0;
      pcnt_q    <= '0;
      wcnt_q    <= '0;
      acc_q     <= '0;
      win_bad_q <= 1'b0;
      per_len_q <= '0;
      per_vld_q <= 1'b0;
      win_sum_q <= '0;
      win_vld_q <= 1'b0;
      err_per_q <= 1'b0;
      err_win_q <= 1'b0;
      locked_q  <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      d1_q      <= d1_d;
      pcnt_q    <= pcnt_d;
      wcnt_q    <= wcnt_d;
      acc_q     <= acc_d;
      win_bad_q <= win_bad_d;
      per_len_q <= per_len_d;
      per_vld_q <= per_vld_d;
      win_sum_q <= win_sum_d;
      win_vld_q <= win_vld_d;
      err_per_q <= err_per_d;
      err_win_q <= err_win_d;
      locked_q  <= locked_d;
      sticky_q  <= sticky_d;
    end
  end

  assign mon.per_len    = per_len_q;
  assign mon.per_vld    = per_vld_q;
  assign mon.win_sum    = win_sum_q;
  assign mon.win_vld    = win_vld_q;
  assign mon.err_per    = err_per_q;
  assign mon.err_win    = err_win_q;
  assign mon.err_sticky = sticky_q;
  assign mon.locked     = locked_q;
  assign mon.dbg_state  = state_q;
endmodule

// File: tb/tb_div_period_mon.sv
// tb_div_period_mon: directed bench for div_period_mon (8.7 divider limits).
module tb_div_period_mon;
  localparam int CNT_W = 4;
  localparam int SUM_W = 7;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic             err;
    logic             lock;
  } win_t;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst;
  always #5 clk_in = ~clk_in;

  div_period_mon_if bus ();

  div_period_mon dut (
    .clk_in (clk_in),
    .rst    (rst),
    .mon    (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  logic [CNT_W-1:0] exp_q[$];
  win_t             win_q[$];
  int               checks = 0;
  int               errors = 0;
  int               prev_len = 0;
  bit               tmo_phase = 1'b0;
  logic [CNT_W-1:0] mon_p;
  win_t             mon_w;

  int pat  [10] = '{9, 9, 8, 9, 9, 8, 9, 9, 9, 8};
  int pat7 [10] = '{9, 9, 7, 9, 9, 8, 9, 9, 9, 8};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One period of p clk_in cycles, starting with a rise. The rise closes the
  // previous period, whose length is then queued as the expected per_len.
  task automatic drive_period(input int p);
    int hi;
    hi = p / 2;
    @(negedge clk_in);
    bus.clr = 1'b0;
    if (prev_len > 0) exp_q.push_back(CNT_W'(prev_len));
    bus.clk_div_in = 1'b1;
    prev_len = p;
    for (int k = 1; k < p; k++) begin
      @(negedge clk_in);
      bus.clk_div_in = (k < hi);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_per_len"},  bus.per_len, 0);
    check({tag, "_per_vld"},  bus.per_vld, 0);
    check({tag, "_win_sum"},  bus.win_sum, 0);
    check({tag, "_win_vld"},  bus.win_vld, 0);
    check({tag, "_err_per"},  bus.err_per, 0);
    check({tag, "_err_win"},  bus.err_win, 0);
    check({tag, "_sticky"},   bus.err_sticky, 0);
    check({tag, "_locked"},   bus.locked, 0);
    check({tag, "_state"},    bus.dbg_state, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_in) begin
    if (rst === 1'b1) begin
      if (bus.per_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_per_vld", bus.per_vld, 0);
        end else begin
          mon_p = exp_q.pop_front();
          check("per_len", bus.per_len, mon_p);
          check("err_per", bus.err_per, (mon_p < 8 || mon_p > 9));
          if (mon_p < 8 || mon_p > 9) check("locked_on_err_per", bus.locked, 0);
        end
      end else if (bus.err_per === 1'b1 && !tmo_phase) begin
        check("err_per_without_per_vld", bus.err_per, 0);
      end
      if (bus.win_vld === 1'b1) begin
        check("win_vld_with_per_vld", bus.per_vld, 1);
        if (win_q.size() == 0) begin
          check("spurious_win_vld", bus.win_vld, 0);
        end else begin
          mon_w = win_q.pop_front();
          check("win_sum", bus.win_sum, mon_w.sum);
          check("err_win", bus.err_win, mon_w.err);
          check("locked_at_win", bus.locked, mon_w.lock);
        end
      end else if (bus.err_win === 1'b1) begin
        check("err_win_without_win_vld", bus.err_win, 0);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int first_err;
    rst = 1'b0;
    bus.clk_div_in = 1'b0;
    bus.clr = 1'b0;

    // Expected windows, hand-computed: {sum, err_win, locked}
    win_q.push_back('{sum: 7'd87, err: 1'b0, lock: 1'b1});
    win_q.push_back('{sum: 7'd87, err: 1'b0, lock: 1'b1});
    win_q.push_back('{sum: 7'd87, err: 1'b0, lock: 1'b1});
    win_q.push_back('{sum: 7'd86, err: 1'b1, lock: 1'b0});
    win_q.push_back('{sum: 7'd90, err: 1'b1, lock: 1'b0});
    win_q.push_back('{sum: 7'd87, err: 1'b0, lock: 1'b1});
    win_q.push_back('{sum: 7'd87, err: 1'b0, lock: 1'b1});

    repeat (3) @(negedge clk_in);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk_in);

    // Three good windows of the 8.7 pattern
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < 10; i++) drive_period(pat[i]);
    check("locked_good_stream", bus.locked, 1);
    check("sticky_good_stream", bus.err_sticky, 0);

    // Window with one 7-cycle period
    for (int i = 0; i < 10; i++) begin
      drive_period(pat7[i]);
      if (i == 3) begin
        check("locked_after_short", bus.locked, 0);
        check("sticky_after_short", bus.err_sticky, 1);
      end
    end

    // Constant 9s; clr alone after the first period
    drive_period(9);
    check("sticky_before_clr", bus.err_sticky, 1);
    bus.clr = 1'b1;
    drive_period(9);
    check("sticky_clr_alone", bus.err_sticky, 0);
    for (int i = 0; i < 8; i++) drive_period(9);

    // Closing rise, then hold low: timeout; clr coincides with err_win
    @(negedge clk_in);
    exp_q.push_back(CNT_W'(prev_len));
    bus.clk_div_in = 1'b1;
    prev_len = 0;
    tmo_phase = 1'b1;
    first_err = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_in);
      bus.clk_div_in = 1'b0;
      bus.clr = (k == 1);
      if (k == 1) check("err_win_all_nines", bus.err_win, 1);
      if (k == 2) check("sticky_set_wins_over_clr", bus.err_sticky, 1);
      if (k > 1 && bus.err_per === 1'b1 && first_err == 0) begin
        first_err = k;
        check("timeout_per_vld", bus.per_vld, 0);
        check("timeout_state_idle", bus.dbg_state, 0);
        check("timeout_locked", bus.locked, 0);
      end
    end
    check("timeout_cycle", first_err, 10);
    tmo_phase = 1'b0;

    // Recovery: first rise silent, then a clean window
    for (int i = 0; i < 10; i++) drive_period(pat[i]);

    // Reset in the middle of a window
    for (int i = 0; i < 4; i++) drive_period(pat[i]);
    #2 rst = 1'b0;
    #1 check_all_zero("async_reset");
    prev_len = 0;
    bus.clk_div_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) drive_period(pat[i]);
    drive_period(8);
    @(negedge clk_in);
    check("locked_after_reset_window", bus.locked, 1);
    check("sticky_after_reset_window", bus.err_sticky, 0);
    check("per_queue_drained", exp_q.size(), 0);
    check("win_queue_drained", win_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
